// File: rtl/vliw_forward_unit_if.sv
// Slot-2 forwarding bus: EX sources, in-flight lane producers, forward selects and kept values.
// Combinational request/response bus with no valid/ready handshake; it is sampled every cycle.
interface vliw_forward_unit_if;
    logic [5:0]  rsE2;
    logic [5:0]  rtE2;
    logic        useRsE2;
    logic        useRtE2;
    logic [5:0]  writeRegM1;
    logic [5:0]  writeRegM2;
    logic        RegWriteM1;
    logic        RegWriteM2;
    logic [5:0]  writeRegM3;
    logic [5:0]  writeRegM4;
    logic        MemReadM3;
    logic        MemReadM4;
    logic [5:0]  writeRegW3;
    logic [5:0]  writeRegW4;
    logic        RegWriteW3;
    logic        RegWriteW4;
    logic [31:0] write_backM1;
    logic [31:0] write_backM2;
    logic [31:0] read_dataW3;
    logic [31:0] read_dataW4;
    logic        stallE;
    logic [3:0]  ForwardaE2;
    logic [3:0]  ForwardbE2;
    logic [31:0] write_backKept1;
    logic [31:0] write_backKept2;
    logic [31:0] read_dataKept3;
    logic [31:0] read_dataKept4;
    logic        stallReqE2;
    logic        dbg_hold;

    modport slave (
        input  rsE2, rtE2, useRsE2, useRtE2,
        input  writeRegM1, writeRegM2, RegWriteM1, RegWriteM2,
        input  writeRegM3, writeRegM4, MemReadM3, MemReadM4,
        input  writeRegW3, writeRegW4, RegWriteW3, RegWriteW4,
        input  write_backM1, write_backM2, read_dataW3, read_dataW4,
        input  stallE,
        output ForwardaE2, ForwardbE2,
        output write_backKept1, write_backKept2, read_dataKept3, read_dataKept4,
        output stallReqE2, dbg_hold
    );

    modport master (
        output rsE2, rtE2, useRsE2, useRtE2,
        output writeRegM1, writeRegM2, RegWriteM1, RegWriteM2,
        output writeRegM3, writeRegM4, MemReadM3, MemReadM4,
        output writeRegW3, writeRegW4, RegWriteW3, RegWriteW4,
        output write_backM1, write_backM2, read_dataW3, read_dataW4,
        output stallE,
        input  ForwardaE2, ForwardbE2,
        input  write_backKept1, write_backKept2, read_dataKept3, read_dataKept4,
        input  stallReqE2, dbg_hold
    );
endinterface

// File: rtl/vliw_forward_unit.sv
// Slot-2 forwarding / load-use hazard unit with kept-producer registers across EX stalls.
// Optional feature macro: FWD_ZERO_REG_EN (register 0 never forwards and never causes a load-use stall).
module vliw_forward_unit (
    input  logic               clk,
    input  logic               rst,
    vliw_forward_unit_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Lane index: 0 = M1, 1 = M2, 2 = W3, 3 = W4.
    state_t           state_q;
    logic [3:0]       kept_valid_q;
    logic [3:0][5:0]  kept_reg_q;
    logic [3:0][31:0] kept_data_q;

    logic [3:0]       live_en;
    logic [3:0][5:0]  live_reg;
    logic [3:0][31:0] live_data;

    assign live_en   = {bus.RegWriteW4, bus.RegWriteW3, bus.RegWriteM2, bus.RegWriteM1};
    assign live_reg  = {bus.writeRegW4, bus.writeRegW3, bus.writeRegM2, bus.writeRegM1};
    assign live_data = {bus.read_dataW4, bus.read_dataW3, bus.write_backM2, bus.write_backM1};

    function automatic logic src_active(input logic [5:0] src, input logic use_src);
        logic ok;
        ok = use_src;
`ifdef FWD_ZERO_REG_EN
        if (src == 6'd0) ok = 1'b0;
`endif
        return ok;
    endfunction

    // Live producers beat kept ones; within each group the younger/second lane wins.
    function automatic logic [3:0] fwd_code(
        input logic [5:0]      src,
        input logic            use_src,
        input logic [3:0]      len,
        input logic [3:0][5:0] lreg,
        input logic [3:0]      kv,
        input logic [3:0][5:0] kr
    );
        logic [3:0] lm;
        logic [3:0] km;
        logic [3:0] code;
        for (int k = 0; k < 4; k++) begin
            lm[k] = len[k] && (lreg[k] == src);
            km[k] = kv[k] && (kr[k] == src);
        end
        code = 4'b0000;
        if (!src_active(src, use_src)) code = 4'b0000;
        else if (lm[1])                code = 4'b0010;
        else if (lm[0])                code = 4'b0001;
        else if (lm[3])                code = 4'b0100;
        else if (lm[2])                code = 4'b0011;
        else if (km[1])                code = 4'b1001;
        else if (km[0])                code = 4'b1000;
        else if (km[3])                code = 4'b0110;
        else if (km[2])                code = 4'b0101;
        return code;
    endfunction

    function automatic logic load_use(
        input logic [5:0] src,
        input logic       use_src,
        input logic [5:0] r3,
        input logic       m3,
        input logic [5:0] r4,
        input logic       m4
    );
        return src_active(src, use_src) && ((m3 && (r3 == src)) || (m4 && (r4 == src)));
    endfunction

    logic [3:0] fwd_a;
    logic [3:0] fwd_b;
    logic       stall_req;

    always_comb begin
        fwd_a     = fwd_code(bus.rsE2, bus.useRsE2, live_en, live_reg, kept_valid_q, kept_reg_q);
        fwd_b     = fwd_code(bus.rtE2, bus.useRtE2, live_en, live_reg, kept_valid_q, kept_reg_q);
        stall_req = load_use(bus.rsE2, bus.useRsE2, bus.writeRegM3, bus.MemReadM3,
                             bus.writeRegM4, bus.MemReadM4)
                  | load_use(bus.rtE2, bus.useRtE2, bus.writeRegM3, bus.MemReadM3,
                             bus.writeRegM4, bus.MemReadM4);
        if (rst) begin
            fwd_a     = 4'b0000;
            fwd_b     = 4'b0000;
            stall_req = 1'b0;
        end
    end

    // Capture happens only on the IDLE->HOLD edge; a held stall never recaptures.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            kept_valid_q <= '0;
            kept_reg_q   <= '0;
            kept_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.stallE) begin
                        state_q      <= HOLD;
                        kept_valid_q <= live_en;
                        kept_reg_q   <= live_reg;
                        kept_data_q  <= live_data;
                    end
                end
                HOLD: begin
                    if (!bus.stallE) begin
                        state_q      <= IDLE;
                        kept_valid_q <= '0;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    kept_valid_q <= '0;
                end
            endcase
        end
    end

    assign bus.ForwardaE2      = fwd_a;
    assign bus.ForwardbE2      = fwd_b;
    assign bus.stallReqE2      = stall_req;
    assign bus.write_backKept1 = kept_data_q[0];
    assign bus.write_backKept2 = kept_data_q[1];
    assign bus.read_dataKept3  = kept_data_q[2];
    assign bus.read_dataKept4  = kept_data_q[3];
    assign bus.dbg_hold        = (state_q == HOLD);

endmodule

// File: tb/tb_vliw_forward_unit.sv
// Directed bench for vliw_forward_unit: driver pushes hand-computed expectations, monitor pops and compares.
module tb_vliw_forward_unit;
    localparam int W = 138;

    logic clk;
    logic rst;

    vliw_forward_unit_if bus ();

    vliw_forward_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           total;
    int           bad;
    logic         zero_en;

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic clear_in();
        bus.rsE2 = '0;          bus.rtE2 = '0;
        bus.useRsE2 = 1'b0;     bus.useRtE2 = 1'b0;
        bus.writeRegM1 = '0;    bus.writeRegM2 = '0;
        bus.RegWriteM1 = 1'b0;  bus.RegWriteM2 = 1'b0;
        bus.writeRegM3 = '0;    bus.writeRegM4 = '0;
        bus.MemReadM3 = 1'b0;   bus.MemReadM4 = 1'b0;
        bus.writeRegW3 = '0;    bus.writeRegW4 = '0;
        bus.RegWriteW3 = 1'b0;  bus.RegWriteW4 = 1'b0;
        bus.write_backM1 = '0;  bus.write_backM2 = '0;
        bus.read_dataW3 = '0;   bus.read_dataW4 = '0;
        bus.stallE = 1'b0;
    endtask

    task automatic next_vec();
        @(posedge clk);
        #1;
        clear_in();
    endtask

    task automatic push_exp(input string nm, input logic hold, input logic [3:0] fa,
                            input logic [3:0] fb, input logic sr,
                            input logic [31:0] k1, input logic [31:0] k2,
                            input logic [31:0] k3, input logic [31:0] k4);
        exp_q.push_back({hold, fa, fb, sr, k1, k2, k3, k4});
        name_q.push_back(nm);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] e;
            logic [W-1:0] a;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {bus.dbg_hold, bus.ForwardaE2, bus.ForwardbE2, bus.stallReqE2,
                  bus.write_backKept1, bus.write_backKept2, bus.read_dataKept3, bus.read_dataKept4};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL %s: got hold=%b fa=%b fb=%b st=%b k=%h_%h_%h_%h required hold=%b fa=%b fb=%b st=%b k=%h_%h_%h_%h",
                         nm, a[137], a[136:133], a[132:129], a[128], a[127:96], a[95:64], a[63:32], a[31:0],
                         e[137], e[136:133], e[132:129], e[128], e[127:96], e[95:64], e[63:32], e[31:0]);
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
`ifdef FWD_ZERO_REG_EN
        zero_en = 1'b1;
`else
        zero_en = 1'b0;
`endif
        rst = 1'b1;
        clear_in();
        repeat (2) @(posedge clk);
        #1;
        push_exp("reset", 0, 4'h0, 4'h0, 0, 0, 0, 0, 0);

        next_vec(); rst = 1'b0;
        bus.RegWriteM1 = 1; bus.writeRegM1 = 6'd5; bus.rsE2 = 6'd5; bus.useRsE2 = 1;
        push_exp("live_m1", 0, 4'b0001, 4'h0, 0, 0, 0, 0, 0);

        next_vec();
        bus.RegWriteM1 = 1; bus.writeRegM1 = 6'd5; bus.RegWriteM2 = 1; bus.writeRegM2 = 6'd5;
        bus.rsE2 = 6'd5; bus.useRsE2 = 1;
        push_exp("live_m2_prio", 0, 4'b0010, 4'h0, 0, 0, 0, 0, 0);

        next_vec();
        bus.RegWriteM1 = 1; bus.writeRegM1 = 6'd5; bus.rsE2 = 6'd5; bus.useRsE2 = 0;
        push_exp("unused_src", 0, 4'h0, 4'h0, 0, 0, 0, 0, 0);

        next_vec();
        bus.RegWriteW3 = 1; bus.writeRegW3 = 6'd9; bus.RegWriteW4 = 1; bus.writeRegW4 = 6'd9;
        bus.rtE2 = 6'd9; bus.useRtE2 = 1;
        push_exp("w4_prio", 0, 4'h0, 4'b0100, 0, 0, 0, 0, 0);

        next_vec();
        bus.RegWriteW3 = 1; bus.writeRegW3 = 6'd9; bus.rtE2 = 6'd9; bus.useRtE2 = 1;
        push_exp("w3_only", 0, 4'h0, 4'b0011, 0, 0, 0, 0, 0);

        next_vec();
        bus.RegWriteW3 = 1; bus.writeRegW3 = 6'd9; bus.RegWriteM1 = 1; bus.writeRegM1 = 6'd9;
        bus.rtE2 = 6'd9; bus.useRtE2 = 1;
        push_exp("m1_over_w3", 0, 4'h0, 4'b0001, 0, 0, 0, 0, 0);

        next_vec();
        bus.MemReadM4 = 1; bus.writeRegM4 = 6'd12; bus.rtE2 = 6'd12; bus.useRtE2 = 1;
        push_exp("load_use_m4", 0, 4'h0, 4'h0, 1, 0, 0, 0, 0);

        next_vec();
        bus.MemReadM4 = 1; bus.writeRegM4 = 6'd12; bus.rtE2 = 6'd12; bus.useRtE2 = 0;
        push_exp("load_use_unused", 0, 4'h0, 4'h0, 0, 0, 0, 0, 0);

        next_vec();
        bus.MemReadM3 = 1; bus.writeRegM3 = 6'd20; bus.rsE2 = 6'd20; bus.useRsE2 = 1;
        push_exp("load_use_m3", 0, 4'h0, 4'h0, 1, 0, 0, 0, 0);

        // first stall cycle: live forward, capture at the edge
        next_vec();
        bus.stallE = 1;
        bus.RegWriteM1 = 1; bus.writeRegM1 = 6'd7; bus.write_backM1 = 32'hDEADBEEF;
        bus.writeRegM2 = 6'd8; bus.write_backM2 = 32'h0000_2222;
        bus.RegWriteW3 = 1; bus.writeRegW3 = 6'd3; bus.read_dataW3 = 32'h3333_0003;
        bus.writeRegW4 = 6'd4; bus.read_dataW4 = 32'h0000_4444;
        bus.rsE2 = 6'd7; bus.useRsE2 = 1;
        push_exp("stall1_live", 0, 4'b0001, 4'h0, 0, 0, 0, 0, 0);

        next_vec();
        bus.stallE = 1; bus.rsE2 = 6'd7; bus.useRsE2 = 1; bus.rtE2 = 6'd3; bus.useRtE2 = 1;
        push_exp("stall2_kept", 1, 4'b1000, 4'b0101, 0,
                 32'hDEADBEEF, 32'h0000_2222, 32'h3333_0003, 32'h0000_4444);

        next_vec();
        bus.stallE = 1; bus.RegWriteW3 = 1; bus.writeRegW3 = 6'd7; bus.read_dataW3 = 32'h9999_9999;
        bus.rsE2 = 6'd7; bus.useRsE2 = 1; bus.rtE2 = 6'd8; bus.useRtE2 = 1;
        push_exp("stall3_live_over_kept", 1, 4'b0011, 4'h0, 0,
                 32'hDEADBEEF, 32'h0000_2222, 32'h3333_0003, 32'h0000_4444);

        next_vec();
        bus.rsE2 = 6'd7; bus.useRsE2 = 1; bus.rtE2 = 6'd3; bus.useRtE2 = 1;
        push_exp("release_cycle", 1, 4'b1000, 4'b0101, 0,
                 32'hDEADBEEF, 32'h0000_2222, 32'h3333_0003, 32'h0000_4444);

        next_vec();
        bus.rsE2 = 6'd7; bus.useRsE2 = 1; bus.rtE2 = 6'd3; bus.useRtE2 = 1;
        push_exp("after_release", 0, 4'h0, 4'h0, 0,
                 32'hDEADBEEF, 32'h0000_2222, 32'h3333_0003, 32'h0000_4444);

        // stallE 1,0,1 pattern
        next_vec();
        bus.stallE = 1;
        bus.writeRegM1 = 6'd11; bus.write_backM1 = 32'h1111_0001;
        bus.RegWriteM2 = 1; bus.writeRegM2 = 6'd10; bus.write_backM2 = 32'hAAAA_0002;
        bus.writeRegW3 = 6'd3; bus.read_dataW3 = 32'h0000_0055;
        bus.RegWriteW4 = 1; bus.writeRegW4 = 6'd13; bus.read_dataW4 = 32'h6666_0004;
        bus.rsE2 = 6'd10; bus.useRsE2 = 1; bus.rtE2 = 6'd13; bus.useRtE2 = 1;
        push_exp("stallB_live", 0, 4'b0010, 4'b0100, 0,
                 32'hDEADBEEF, 32'h0000_2222, 32'h3333_0003, 32'h0000_4444);

        next_vec();
        bus.rsE2 = 6'd10; bus.useRsE2 = 1; bus.rtE2 = 6'd13; bus.useRtE2 = 1;
        push_exp("kept2_kept4", 1, 4'b1001, 4'b0110, 0,
                 32'h1111_0001, 32'hAAAA_0002, 32'h0000_0055, 32'h6666_0004);

        next_vec();
        bus.stallE = 1;
        bus.RegWriteM1 = 1; bus.writeRegM1 = 6'd21; bus.write_backM1 = 32'h0000_0101;
        bus.writeRegM2 = 6'd22; bus.write_backM2 = 32'h0000_0202;
        bus.writeRegW3 = 6'd23; bus.read_dataW3 = 32'h0000_0303;
        bus.writeRegW4 = 6'd24; bus.read_dataW4 = 32'h0000_0404;
        bus.rsE2 = 6'd21; bus.useRsE2 = 1;
        push_exp("restall_idle", 0, 4'b0001, 4'h0, 0,
                 32'h1111_0001, 32'hAAAA_0002, 32'h0000_0055, 32'h6666_0004);

        next_vec();
        bus.stallE = 1; bus.rsE2 = 6'd21; bus.useRsE2 = 1;
        push_exp("restall_kept", 1, 4'b1000, 4'h0, 0,
                 32'h0000_0101, 32'h0000_0202, 32'h0000_0303, 32'h0000_0404);

        // reset mid-HOLD
        next_vec();
        rst = 1'b1; bus.stallE = 1;
        bus.RegWriteM1 = 1; bus.writeRegM1 = 6'd21;
        bus.MemReadM3 = 1; bus.writeRegM3 = 6'd21;
        bus.rsE2 = 6'd21; bus.useRsE2 = 1;
        push_exp("rst_forces_zero", 1, 4'h0, 4'h0, 0,
                 32'h0000_0101, 32'h0000_0202, 32'h0000_0303, 32'h0000_0404);

        next_vec();
        rst = 1'b0; bus.stallE = 1; bus.rsE2 = 6'd21; bus.useRsE2 = 1;
        push_exp("after_rst", 0, 4'h0, 4'h0, 0, 0, 0, 0, 0);

        // zero register
        next_vec();
        bus.RegWriteM1 = 1; bus.writeRegM1 = 6'd0; bus.rsE2 = 6'd0; bus.useRsE2 = 1;
        bus.MemReadM3 = 1; bus.writeRegM3 = 6'd0; bus.rtE2 = 6'd0; bus.useRtE2 = 1;
        push_exp("zero_reg", 1, zero_en ? 4'b0000 : 4'b0001, zero_en ? 4'b0000 : 4'b0001,
                 ~zero_en, 0, 0, 0, 0);

        @(posedge clk);
        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
